matrix_mult_seq: RTL and testbench

- Sequential, handshaked successor to the combinational matrix multiplier: computes C = A×B for square N×N matrices, with optional accumulate C = C_prev + A×B.
- Uses N parallel MAC lanes, one per output column, iterating over rows and inner index. This trades N*N cycles of latency for N multipliers instead of N³.
- Sits between a matrix-operand source and a result consumer.
- Both sides use valid/ready handshakes. Flat packed buses use the existing element ordering: element [i][j] is at bits (i*N+j)*W +: W.

---
 rtl/matrix_mult_seq.sv | 167 ++++++++++++++++
 tb/tb_matrix_mult_seq.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_mult_seq.sv
// Sequential N x N matrix multiplier with optional accumulate onto the previous result.
// One MAC lane per output column; each row takes N cycles, so a full result takes N*N cycles.
module matrix_mult_seq #(
    parameter int unsigned  N      = 3,
    parameter int unsigned  DW     = 8,
    parameter int unsigned  SIGNED = 0,
    localparam int unsigned AW     = 2 * DW + $clog2(N)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                acc_mode,
    input  logic [N*N*DW-1:0]   A_flat,
    input  logic [N*N*DW-1:0]   B_flat,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N*N*AW-1:0]   C_flat,
    output logic                busy
);

    localparam int unsigned CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           in_ready_d, busy_d, out_valid_d;
    logic           accept_c, row_end_c, last_row_c;
    logic [CW-1:0]  i_q, k_q, i_nxt_c;
    logic           acc_mode_q;

    logic [DW-1:0]  a_m   [N][N];
    logic [DW-1:0]  b_m   [N][N];
    logic [AW-1:0]  c_m   [N][N];
    logic [AW-1:0]  acc_q [N];
    logic [AW-1:0]  sum_c [N];

    // Widen an operand to the result width, honouring the operand signedness.
    function automatic logic [AW-1:0] ext(input logic [DW-1:0] x);
        logic sx;
        sx = (SIGNED != 0) ? x[DW-1] : 1'b0;
        return {{(AW-DW){sx}}, x};
    endfunction

    assign row_end_c  = (k_q == CW'(N - 1));
    assign last_row_c = (i_q == CW'(N - 1));
    assign i_nxt_c    = last_row_c ? '0 : i_q + CW'(1);

    // One MAC per output column for the current (i, k) step.
    always_comb begin
        for (int unsigned j = 0; j < N; j++) begin
            sum_c[j] = '0;
        end
        for (int unsigned j = 0; j < N; j++) begin
            sum_c[j] = acc_q[j] + ext(a_m[i_q][k_q]) * ext(b_m[k_q][j]);
        end
    end

    // State register and registered handshake/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_ready  <= in_ready_d;
            busy      <= busy_d;
            out_valid <= out_valid_d;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_d     = state_q;
        in_ready_d  = 1'b0;
        busy_d      = 1'b0;
        out_valid_d = 1'b0;
        accept_c    = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready) begin
                    accept_c   = 1'b1;
                    state_d    = COMPUTE;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            COMPUTE: begin
                busy_d = 1'b1;
                if (row_end_c && last_row_c) begin
                    state_d     = DONE;
                    busy_d      = 1'b0;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                out_valid_d = 1'b1;
                if (out_valid && out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                in_ready_d = 1'b1;
            end
        endcase
    end

    // Operand capture, loop counters, lane accumulators and the result matrix.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q        <= '0;
            k_q        <= '0;
            acc_mode_q <= 1'b0;
            for (int unsigned r = 0; r < N; r++) begin
                acc_q[r] <= '0;
                for (int unsigned c = 0; c < N; c++) begin
                    a_m[r][c] <= '0;
                    b_m[r][c] <= '0;
                    c_m[r][c] <= '0;
                end
            end
        end else if (accept_c) begin
            acc_mode_q <= acc_mode;
            i_q        <= '0;
            k_q        <= '0;
            for (int unsigned r = 0; r < N; r++) begin
                acc_q[r] <= acc_mode ? c_m[0][r] : '0;
                for (int unsigned c = 0; c < N; c++) begin
                    a_m[r][c] <= A_flat[(r*N+c)*DW +: DW];
                    b_m[r][c] <= B_flat[(r*N+c)*DW +: DW];
                end
            end
        end else if (state_q == COMPUTE) begin
            if (row_end_c) begin
                // Row complete: commit it and seed the lanes for the next row.
                for (int unsigned j = 0; j < N; j++) begin
                    c_m[i_q][j] <= sum_c[j];
                    acc_q[j]    <= (acc_mode_q && !last_row_c) ? c_m[i_nxt_c][j] : '0;
                end
                k_q <= '0;
                i_q <= i_nxt_c;
            end else begin
                for (int unsigned j = 0; j < N; j++) begin
                    acc_q[j] <= sum_c[j];
                end
                k_q <= k_q + CW'(1);
            end
        end
    end

    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            assign C_flat[(r*N+c)*AW +: AW] = c_m[r][c];
        end
    end

endmodule

// File: tb/tb_matrix_mult_seq.sv
// Bench for matrix_mult_seq: an unsigned and a signed instance, checked against a
// plain-arithmetic matrix model plus a few hand-computed literal results.
module tb_matrix_mult_seq;

    localparam int N   = 3;
    localparam int DW  = 8;
    localparam int AW  = 2 * DW + $clog2(N);
    localparam int MW  = N * N * DW;
    localparam int CWD = N * N * AW;

    logic            clk;
    logic            rst_n;
    logic            in_valid  [2];
    logic            in_ready  [2];
    logic            acc_mode  [2];
    logic            out_valid [2];
    logic            out_ready [2];
    logic            busy      [2];
    logic [MW-1:0]   a_flat    [2];
    logic [MW-1:0]   b_flat    [2];
    logic [CWD-1:0]  c_flat    [2];
    logic [CWD-1:0]  exp_c     [2];

    int total = 0;
    int bad   = 0;

    matrix_mult_seq #(.N(N), .DW(DW), .SIGNED(0)) u_uns (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .acc_mode(acc_mode[0]), .A_flat(a_flat[0]), .B_flat(b_flat[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .C_flat(c_flat[0]), .busy(busy[0])
    );

    matrix_mult_seq #(.N(N), .DW(DW), .SIGNED(1)) u_sgn (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .acc_mode(acc_mode[1]), .A_flat(a_flat[1]), .B_flat(b_flat[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .C_flat(c_flat[1]), .busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [CWD-1:0] act, input logic [CWD-1:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, expv);
        end
    endtask

    function automatic logic [MW-1:0] mat_fill(input logic [DW-1:0] v);
        logic [MW-1:0] m;
        for (int e = 0; e < N*N; e++) m[e*DW +: DW] = v;
        return m;
    endfunction

    function automatic logic [MW-1:0] mat_seq();
        logic [MW-1:0] m;
        for (int e = 0; e < N*N; e++) m[e*DW +: DW] = DW'(e + 1);
        return m;
    endfunction

    function automatic logic [MW-1:0] mat_ident();
        logic [MW-1:0] m;
        m = '0;
        for (int i = 0; i < N; i++) m[(i*N+i)*DW +: DW] = DW'(1);
        return m;
    endfunction

    function automatic logic [MW-1:0] rand_mat();
        logic [MW-1:0] m;
        for (int e = 0; e < N*N; e++) m[e*DW +: DW] = DW'($urandom);
        return m;
    endfunction

    function automatic logic [CWD-1:0] c_seq(input int mul);
        logic [CWD-1:0] c;
        for (int e = 0; e < N*N; e++) c[e*AW +: AW] = AW'((e + 1) * mul);
        return c;
    endfunction

    function automatic logic [CWD-1:0] c_fill(input logic [AW-1:0] v);
        logic [CWD-1:0] c;
        for (int e = 0; e < N*N; e++) c[e*AW +: AW] = v;
        return c;
    endfunction

    // Element value as an integer; instance 1 treats operands as two's complement.
    function automatic longint el(input int d, input logic [MW-1:0] m, input int r, input int c);
        logic [DW-1:0] x;
        x = m[(r*N+c)*DW +: DW];
        if (d == 1) return longint'($signed(x));
        return longint'(x);
    endfunction

    // C = (am ? prev : 0) + A*B, reduced modulo 2^AW.
    function automatic logic [CWD-1:0] model(input int d, input logic [MW-1:0] a,
                                             input logic [MW-1:0] b, input logic am,
                                             input logic [CWD-1:0] prev);
        logic [CWD-1:0] r;
        longint s;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                s = am ? longint'(prev[(i*N+j)*AW +: AW]) : 64'sd0;
                for (int k = 0; k < N; k++) s += el(d, a, i, k) * el(d, b, k, j);
                r[(i*N+j)*AW +: AW] = AW'(s);
            end
        end
        return r;
    endfunction

    // Whenever a result is presented it must match the model and block new input.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst_n && out_valid[d]) begin
                chk("c_flat_while_valid", c_flat[d], exp_c[d]);
                chk("in_ready_low_in_done", in_ready[d], 0);
            end
        end
    end

    task automatic check_lit(input string name, input int d, input logic [CWD-1:0] lit);
        chk({name, "_dut"}, c_flat[d], lit);
        chk({name, "_model"}, exp_c[d], lit);
    endtask

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic start_op(input int d, input logic [MW-1:0] a, input logic [MW-1:0] b,
                            input logic am);
        int t;
        t = 0;
        while (!in_ready[d] && t < 50) begin
            @(posedge clk); #1; t++;
        end
        chk("in_ready_before_accept", in_ready[d], 1);
        a_flat[d]   = a;
        b_flat[d]   = b;
        acc_mode[d] = am;
        in_valid[d] = 1'b1;
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        a_flat[d]   = rand_mat();
        b_flat[d]   = rand_mat();
        acc_mode[d] = 1'($urandom);
        exp_c[d]    = model(d, a, b, am, exp_c[d]);
        chk("busy_after_accept", busy[d], 1);
    endtask

    task automatic wait_done(input int d);
        int lat;
        int bc;
        lat = 0;
        bc  = busy[d] ? 1 : 0;
        while (!out_valid[d] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (busy[d]) bc++;
        end
        chk("latency", lat, N*N);
        chk("busy_cycles", bc, N*N);
    endtask

    task automatic release_out(input int d, input int hold);
        repeat (hold) begin
            @(posedge clk); #1;
        end
        out_ready[d] = 1'b1;
        @(posedge clk); #1;
        out_ready[d] = 1'b0;
        chk("out_valid_cleared", out_valid[d], 0);
        chk("in_ready_after_release", in_ready[d], 1);
    endtask

    task automatic op(input int d, input logic [MW-1:0] a, input logic [MW-1:0] b,
                      input logic am, input int hold);
        start_op(d, a, b, am);
        wait_done(d);
        release_out(d, hold);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = 1'b0;
            acc_mode[d]  = 1'b0;
            out_ready[d] = 1'b0;
            a_flat[d]    = '0;
            b_flat[d]    = '0;
            exp_c[d]     = '0;
        end
        #12;
        for (int d = 0; d < 2; d++) begin
            chk("reset_in_ready", in_ready[d], 1);
            chk("reset_out_valid", out_valid[d], 0);
            chk("reset_busy", busy[d], 0);
            chk("reset_c_flat", c_flat[d], '0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Identity, then accumulate onto it, then overwrite again.
        op(0, mat_ident(), mat_seq(), 1'b0, 0);
        check_lit("identity", 0, c_seq(1));
        op(0, mat_ident(), mat_seq(), 1'b1, 1);
        check_lit("accumulate", 0, c_seq(2));
        op(0, mat_ident(), mat_seq(), 1'b0, 0);
        check_lit("overwrite", 0, c_seq(1));

        // Unsigned extremes and random operand sets.
        op(0, mat_fill(8'hFF), mat_fill(8'hFF), 1'b0, 2);
        check_lit("unsigned_max", 0, c_fill(AW'(195075)));
        for (int n = 0; n < 5; n++) op(0, rand_mat(), rand_mat(), 1'b0, int'($urandom_range(0, 3)));
        for (int n = 0; n < 4; n++) op(0, rand_mat(), rand_mat(), 1'($urandom), int'($urandom_range(0, 2)));

        // Signed: first op accumulates onto the post-reset zero result.
        op(1, mat_fill(8'h80), mat_fill(8'h80), 1'b1, 0);
        check_lit("signed_min", 1, c_fill(AW'(49152)));
        op(1, mat_fill(8'hFF), mat_fill(8'h02), 1'b0, 1);
        check_lit("signed_neg", 1, c_fill(AW'('h3FFFA)));
        for (int n = 0; n < 5; n++) op(1, rand_mat(), rand_mat(), 1'($urandom), int'($urandom_range(0, 2)));

        // Backpressure: result held, new operands refused while DONE.
        start_op(0, mat_seq(), mat_ident(), 1'b0);
        wait_done(0);
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (cyc == 5) begin
                a_flat[0]   = rand_mat();
                b_flat[0]   = rand_mat();
                acc_mode[0] = 1'b1;
                in_valid[0] = 1'b1;
            end
            if (cyc == 7) in_valid[0] = 1'b0;
            @(posedge clk); #1;
            chk("bp_in_ready", in_ready[0], 0);
            chk("bp_out_valid", out_valid[0], 1);
        end
        in_valid[0] = 1'b0;
        check_lit("bp_hold", 0, c_seq(1));
        release_out(0, 0);
        @(posedge clk); #1;
        chk("bp_not_accepted", busy[0], 0);
        chk("bp_retained", c_flat[0], exp_c[0]);

        // Asynchronous reset in the fourth COMPUTE cycle.
        start_op(0, rand_mat(), rand_mat(), 1'b0);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("midrst_out_valid", out_valid[d], 0);
            chk("midrst_busy", busy[d], 0);
            chk("midrst_in_ready", in_ready[d], 1);
            chk("midrst_c_flat", c_flat[d], '0);
            exp_c[d] = '0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        op(0, mat_ident(), mat_seq(), 1'b1, 0);
        check_lit("after_reset", 0, c_seq(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
